// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths and FSM state encoding for the memory arbiter
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_e;
endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-way round-robin pick (req0_i/req1_i, en_i qualifier -> win_id_o, win_vld_o), last winner resets to 1
module arb_rr2 (
  input  logic clk,
  input  logic reset,
  input  logic req0_i,
  input  logic req1_i,
  input  logic en_i,
  output logic win_id_o,
  output logic win_vld_o
);
  logic last_q, last_d;
  always_comb begin
    win_vld_o = en_i & (req0_i | req1_i);
    win_id_o  = (req0_i & req1_i) ? ~last_q : req1_i;
    last_d    = win_vld_o ? win_id_o : last_q;
  end
  always_ff @(posedge clk) last_q <= reset ? 1'b1 : last_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises two requesters (req/we/addr/wdata in, gnt/done/rdata out) onto one memory port (mem_*), busy/state for debug
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [1:0]        state,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic id_q, we_q, win_id, win_vld, last_wait, issue, fin;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  arb_rr2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req0_i   (req0),
    .req1_i   (req1),
    .en_i     (state_q == IDLE),
    .win_id_o (win_id),
    .win_vld_o(win_vld)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    last_wait = (state_q == WAIT) && (cnt_q == 2'd1);
    state_d   = (state_q == IDLE)  ? (win_vld ? ISSUE : IDLE) :
                (state_q == ISSUE) ? WAIT :
                (state_q == WAIT)  ? (last_wait ? DONE : WAIT) : IDLE;
    cnt_d     = (state_q == ISSUE) ? 2'(MEM_LAT) :
                (state_q == WAIT)  ? cnt_q - 2'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (win_vld) begin
        id_q    <= win_id;
        we_q    <= win_id ? we1 : we0;
        addr_q  <= win_id ? addr1 : addr0;
        wdata_q <= win_id ? wdata1 : wdata0;
      end
      if (last_wait) rdata_q <= we_q ? '0 : mem_rdata;
    end
  end
  always_comb begin
    issue     = state_q == ISSUE;
    fin       = state_q == DONE;
    gnt0      = issue & ~id_q;
    gnt1      = issue & id_q;
    done0     = fin & ~id_q;
    done1     = fin & id_q;
    rdata     = fin ? rdata_q : '0;
    busy      = state_q != IDLE;
    state     = state_q;
    mem_en    = issue;
    mem_we    = issue & we_q;
    mem_addr  = issue ? addr_q : '0;
    mem_wdata = issue ? wdata_q : '0;
  end
endmodule
